// File: rtl/sccb_target_if.sv
// Bus and register-port bundle for the SCCB target engine.
// The slave modport is the target side; the master modport is the initiator/register-file side.
interface sccb_target_if;
  logic       sio_c;
  logic       sio_d_in;
  logic       sio_d_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    input  sio_c, sio_d_in, reg_rdata,
    output sio_d_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport master (
    output sio_c, sio_d_in, reg_rdata,
    input  sio_d_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );
endinterface

// File: rtl/sccb_target.sv
// SCCB target: oversamples sio_c/sio_d and turns 3-phase write / 2-phase read into register strobes.
// Optional I2C-style ACK on bit 8 of ID/ADDR/WDATA when SCCB_TARGET_ACK_EN is defined.
module sccb_target #(
  parameter logic [6:0] DEVICE_ID = 7'h21
) (
  input  logic         sccb_clk,
  input  logic         sccb_reset,
  sccb_target_if.slave bus
);

`ifdef SCCB_TARGET_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ID, S_ADDR, S_WDATA, S_RDATA, S_SKIP} state_e;

  // [0],[1] synchronizer, [2] history for edge detection
  logic [2:0] c_sync_q, c_sync_d;
  logic [2:0] d_sync_q, d_sync_d;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       rd_cap_q, rd_cap_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;

  logic scl, scl_h, sda, sda_h;
  logic scl_rise, scl_fall, start_c, stop_c;
  logic bit8, id_match;

  always_comb begin
    c_sync_d = {c_sync_q[1:0], bus.sio_c};
    d_sync_d = {d_sync_q[1:0], bus.sio_d_in};
  end

  assign scl      = c_sync_q[1];
  assign scl_h    = c_sync_q[2];
  assign sda      = d_sync_q[1];
  assign sda_h    = d_sync_q[2];
  assign scl_rise = scl & ~scl_h;
  assign scl_fall = ~scl & scl_h;
  assign start_c  = scl & scl_h & sda_h & ~sda;
  assign stop_c   = scl & scl_h & ~sda_h & sda;
  assign bit8     = (cnt_q == 4'd8);
  assign id_match = (shift_q[7:1] == DEVICE_ID);

  // Synchronizers reset to the idle-high bus level so reset itself creates no edges
  always_ff @(posedge sccb_clk) begin
    if (sccb_reset) begin
      c_sync_q <= 3'b111;
      d_sync_q <= 3'b111;
    end else begin
      c_sync_q <= c_sync_d;
      d_sync_q <= d_sync_d;
    end
  end

  always_ff @(posedge sccb_clk) begin
    if (sccb_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start_c) begin
      state_d = S_ID;
      cnt_d   = 4'd0;
    end else if (stop_c) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else if (scl_rise) begin
      case (state_q)
        S_ID, S_ADDR, S_WDATA, S_RDATA: begin
          if (bit8) begin
            cnt_d = 4'd0;
            case (state_q)
              S_ID:    state_d = !id_match ? S_SKIP : (shift_q[0] ? S_RDATA : S_ADDR);
              S_ADDR:  state_d = S_WDATA;
              default: state_d = S_SKIP;
            endcase
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    shift_d  = shift_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    rd_cap_d = re_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    // read data is taken one cycle after the reg_re strobe, well before the next SCL fall
    if (rd_cap_q)
      shift_d = bus.reg_rdata;
    if (start_c) begin
      busy_d = 1'b1;
      oe_d   = 1'b0;
    end else if (stop_c) begin
      busy_d = 1'b0;
      oe_d   = 1'b0;
    end else begin
      if (scl_rise && !bit8 && (state_q == S_ID || state_q == S_ADDR || state_q == S_WDATA))
        shift_d = {shift_q[6:0], sda};
      if (scl_rise && bit8) begin
        case (state_q)
          S_ID:    re_d = id_match & shift_q[0];
          S_ADDR:  addr_d = shift_q;
          S_WDATA: begin
            we_d    = 1'b1;
            wdata_d = shift_q;
          end
          default: ;
        endcase
      end
      if (scl_fall) begin
        case (state_q)
          S_ID:           oe_d = ACK_EN & bit8 & id_match;
          S_ADDR, S_WDATA: oe_d = ACK_EN & bit8;
          // MSB first: bit index 7-cnt is ~cnt[2:0]; NA slot released
          S_RDATA:        oe_d = bit8 ? 1'b0 : ~shift_q[~cnt_q[2:0]];
          default:        oe_d = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge sccb_clk) begin
    if (sccb_reset) begin
      shift_q  <= 8'h00;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      rd_cap_q <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      rd_cap_q <= rd_cap_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.sio_d_oe  = oe_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: table of bus transactions plus hand-written abort/reset sequences,
// with register strobes checked against a scoreboard queue.
module tb_sccb_target;
`ifdef SCCB_TARGET_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif
  localparam int Q = 40;  // quarter SCL period: SCL period is 16 sccb_clk

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] rdata_m = 8'h00;

  sccb_target_if bus();
  assign bus.sio_c     = scl_m;
  assign bus.sio_d_in  = sda_m & ~bus.sio_d_oe;
  assign bus.reg_rdata = rdata_m;

  sccb_target dut (.sccb_clk(clk), .sccb_reset(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    bit         is_we;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  // kind: 0 = 2-phase write, 1 = 3-phase write, 2 = 2-phase read
  typedef struct {
    int         kind;
    logic [7:0] id;
    logic [7:0] addr;
    logic [7:0] data;
    bit         hit;
    logic [7:0] addr_after;
    logic [7:0] rbyte;
  } vec_t;
  vec_t vecs[9];

  realtime t_rise = 0;
  always @(posedge scl_m) t_rise = $realtime;

  task automatic on_strobe(input bit is_we);
    exp_t e;
    check("strobe_expected", int'(sb_q.size() > 0), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check(is_we ? "strobe_kind_we" : "strobe_kind_re", int'(is_we), int'(e.is_we));
    check("strobe_addr", int'(bus.reg_addr), int'(e.addr));
    if (is_we) check("strobe_wdata", int'(bus.reg_wdata), int'(e.data));
    check("strobe_latency_ok", int'(($realtime - t_rise) <= 45.0), 1);
  endtask

  logic prev_oe = 1'b0;
  int   oe_viol = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_we) on_strobe(1'b1);
      if (bus.reg_re) on_strobe(1'b0);
      if (bus.sio_d_oe !== prev_oe && scl_m) oe_viol++;
    end
    prev_oe = bus.sio_d_oe;
  end

  task automatic bus_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic bit_x(input bit b, output bit line);
    sda_m = b; #Q; scl_m = 1'b1; #Q; line = bus.sio_d_in; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic xfer_byte(input logic [7:0] b, input bit nine, output logic [7:0] got, output bit l9);
    bit l;
    for (int i = 7; i >= 0; i--) begin
      bit_x(b[i], l);
      got[i] = l;
    end
    bit_x(nine, l9);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] got;
    bit         ack;
    string      tag;
    tag = $sformatf("v%0d", idx);
    bus_start();
    check({tag, "_busy_start"}, int'(bus.busy), 1);
    if (v.kind == 2) begin
      rdata_m = v.data;
      if (v.hit) sb_q.push_back('{1'b0, v.addr_after, 8'h00});
      xfer_byte(v.id, 1'b1, got, ack);
      check({tag, "_id_slot"}, int'(ack), int'(!(ACK_EN && v.hit)));
      xfer_byte(8'hFF, 1'b1, got, ack);
      check({tag, "_rbyte"}, int'(got), int'(v.rbyte));
      check({tag, "_na_released"}, int'(ack), 1);
    end else begin
      if (v.kind == 1 && v.hit) sb_q.push_back('{1'b1, v.addr, v.data});
      xfer_byte(v.id, 1'b1, got, ack);
      check({tag, "_id_slot"}, int'(ack), int'(!(ACK_EN && v.hit)));
      xfer_byte(v.addr, 1'b1, got, ack);
      check({tag, "_addr_slot"}, int'(ack), int'(!(ACK_EN && v.hit)));
      if (v.kind == 1) begin
        xfer_byte(v.data, 1'b1, got, ack);
        check({tag, "_data_slot"}, int'(ack), int'(!(ACK_EN && v.hit)));
      end
    end
    bus_stop();
    check({tag, "_busy_stop"}, int'(bus.busy), 0);
    check({tag, "_reg_addr"}, int'(bus.reg_addr), int'(v.addr_after));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got;
    bit         ack;
    bit         l;

    vecs[0] = '{1, 8'h42, 8'h12, 8'h80, 1'b1, 8'h12, 8'h00};
    vecs[1] = '{0, 8'h42, 8'h0A, 8'h00, 1'b1, 8'h0A, 8'h00};
    vecs[2] = '{2, 8'h43, 8'h00, 8'h76, 1'b1, 8'h0A, 8'h76};
    vecs[3] = '{1, 8'h60, 8'h33, 8'h55, 1'b0, 8'h0A, 8'h00};
    vecs[4] = '{2, 8'h61, 8'h00, 8'h5A, 1'b0, 8'h0A, 8'hFF};
    vecs[5] = '{1, 8'h42, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00};
    vecs[6] = '{2, 8'h43, 8'h00, 8'hA5, 1'b1, 8'hFF, 8'hA5};
    vecs[7] = '{1, 8'h42, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00};
    vecs[8] = '{2, 8'h43, 8'h00, 8'h01, 1'b1, 8'h00, 8'h01};

    #30;
    check("rst_oe", int'(bus.sio_d_oe), 0);
    check("rst_we", int'(bus.reg_we), 0);
    check("rst_re", int'(bus.reg_re), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_addr", int'(bus.reg_addr), 0);
    check("rst_wdata", int'(bus.reg_wdata), 0);
    #10 rst = 1'b0;
    #Q;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // STOP after 4 ADDR bits: nothing latched, no strobe
    bus_start();
    xfer_byte(8'h42, 1'b1, got, ack);
    bit_x(1'b1, l); bit_x(1'b0, l); bit_x(1'b1, l); bit_x(1'b1, l);
    bus_stop();
    check("abort_addr_keep", int'(bus.reg_addr), 8'h00);
    check("abort_addr_busy", int'(bus.busy), 0);

    // repeated START mid-WDATA, then a read of the address latched before the abort
    bus_start();
    xfer_byte(8'h42, 1'b1, got, ack);
    xfer_byte(8'h55, 1'b1, got, ack);
    for (int i = 0; i < 5; i++) bit_x(1'b0, l);
    rdata_m = 8'h9E;
    sb_q.push_back('{1'b0, 8'h55, 8'h00});
    bus_start();
    check("rs_busy", int'(bus.busy), 1);
    xfer_byte(8'h43, 1'b1, got, ack);
    check("rs_id_slot", int'(ack), int'(!ACK_EN));
    xfer_byte(8'hFF, 1'b1, got, ack);
    check("rs_rbyte", int'(got), 8'h9E);
    check("rs_na", int'(ack), 1);
    bus_stop();
    check("rs_addr", int'(bus.reg_addr), 8'h55);

    // reset while driving a 0 bit in RDATA
    rdata_m = 8'h00;
    sb_q.push_back('{1'b0, 8'h55, 8'h00});
    bus_start();
    xfer_byte(8'h43, 1'b1, got, ack);
    sda_m = 1'b1;
    #Q;
    check("rd_oe_before_reset", int'(bus.sio_d_oe), 1);
    rst = 1'b1;
    #10;
    check("reset_oe", int'(bus.sio_d_oe), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_addr", int'(bus.reg_addr), 0);
    #10 rst = 1'b0;
    #Q;
    bus_stop();
    check("post_reset_busy", int'(bus.busy), 0);

    // decoding resumes cleanly after reset
    sb_q.push_back('{1'b1, 8'h77, 8'h11});
    bus_start();
    xfer_byte(8'h42, 1'b1, got, ack);
    xfer_byte(8'h77, 1'b1, got, ack);
    xfer_byte(8'h11, 1'b1, got, ack);
    bus_stop();
    check("post_reset_addr", int'(bus.reg_addr), 8'h77);
    #(4*Q);

    check("sb_drained", sb_q.size(), 0);
    check("oe_stable_scl_high", oe_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB target (slave) engine for the camera subsystem. It decodes 3-phase write and 2-phase write plus 2-phase read transactions arriving on sio_c/sio_d, and turns them into single-cycle strobes on a local 8-bit register port. It is used as the sensor-side model and loopback target for the SCCB initiator and as the configuration front end of on-chip camera-emulation logic. It oversamples the bus with the system clock and never drives sio_c.

## Interface
- DEVICE_ID, 7'h21: 7-bit target ID matched against ID-phase bits [7:1]. 0x42 is write, 0x43 is read.
- sccb_clk  input  1  system clock; must be at least 8x the SCL frequency.
- sccb_reset  input  1  reset; synchronous, active-high.
- sio_c  input  1  SCCB clock from the initiator (asynchronous).
- sio_d_in  input  1  SCCB data pad input (asynchronous).
- sio_d_oe  output  1  1 pulls sio_d low (open drain); 0 releases the line.
- reg_addr  output  8  latched sub-address.
- reg_wdata  output  8  write data, valid while reg_we is high.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data, sampled exactly 1 cycle after reg_re.
- busy  output  1  high from START until STOP.

## Operation
- **Input conditioning**
  - sio_c and sio_d_in each pass through 2-flop synchronizers plus a history flop.
  - Edges are detected on the synchronized values only.
- **Bus conditions**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in every state.
- **Bit timing**
  - Sample on SCL rise.
  - Change sio_d_oe only on SCL fall.
  - A 4-bit counter counts 0..8 per phase; bit 8 is the don't-care/NA bit.
- **States:** IDLE, ID, ADDR, WDATA, RDATA, SKIP.
- **Transitions**
  - START from any state goes to ID, clears the bit counter and sets busy. A repeated START aborts the phase in progress with no strobe.
  - ID at bit 8:
    - ID[7:1] != DEVICE_ID goes to SKIP.
    - ID[0]=0 goes to ADDR.
    - ID[0]=1 goes to RDATA and pulses reg_re with the current reg_addr.
  - ADDR at bit 8: latch reg_addr and go to WDATA.
  - WDATA at bit 8: pulse reg_we with reg_wdata = received byte, then go to SKIP. Only one data byte per transaction is accepted.
  - RDATA:
    - Capture reg_rdata into the shift register on the cycle after reg_re.
    - Drive bits MSB first. sio_d_oe = ~bit, updated on each SCL fall starting with the fall that ends ID bit 8.
    - Release at bit 8 (NA) and go to SKIP.
  - SKIP: ignore all bits, sio_d_oe = 0, wait for START or STOP.
  - STOP from any state goes to IDLE, clears busy, sets sio_d_oe = 0. An incomplete phase produces no strobe.
- **reg_addr persistence**
  - reg_addr keeps its value across transactions; a 2-phase write followed by a 2-phase read returns the addressed register.
  - No auto-increment.
- **Reset:** all outputs are 0; state is IDLE; the address and shift registers are 0.

## Timing
- Synchronizer plus edge detection gives 3 sccb_clk from a pin edge to internal detection; the implementation must not exceed 4.
- reg_we and reg_re assert within 4 sccb_clk of the SCL rise of bit 8 and are high for exactly 1 cycle.
- reg_rdata is required 1 cycle after reg_re; no wait states are supported.
- sio_d_oe changes within 4 sccb_clk of an SCL fall and is never changed while SCL is high. This preserves the SDA setup/hold the initiator expects.
- reset asserted mid-transaction: sio_d_oe is 0 on the next cycle; no strobe is issued.
- START and STOP at an SCL-high edge take priority over bit sampling in the same cycle.

## Configuration
- SCCB_TARGET_ACK_EN
  - **Defined:** the target drives sio_d_oe = 1 during bit 8 of ID (on a match), ADDR and WDATA, i.e. an I2C-style ACK.
  - **Undefined:** the target leaves bit 8 undriven in every phase (pure SCCB don't-care).
  - RDATA bit 8 is always released in both cases.

## Test plan
- 3-phase write: ID 0x42, ADDR 0x12, DATA 0x80, STOP -> exactly one reg_we with reg_addr=0x12, reg_wdata=0x80; busy falls after STOP.
- Write 0x42/0x0A, STOP, then read 0x43 with reg_rdata=0x76 -> one reg_re with reg_addr=0x0A; bits 0,1,1,1,0,1,1,0 observed on SCL rises; oe released at NA.
- ID 0x60 -> no reg_we or reg_re; sio_d_oe stays 0 throughout, including with SCCB_TARGET_ACK_EN defined.
- STOP after 4 ADDR bits, then repeated START mid-WDATA -> no reg_we; new ID phase decoded correctly.
- Assert sccb_reset during RDATA while sio_d_oe=1 -> sio_d_oe=0 next cycle, state IDLE, busy=0.
- With SCCB_TARGET_ACK_EN defined: 0x42/0x12/0x80 -> sio_d_oe=1 during the three bit-8 slots only. Without the macro: sio_d_oe stays 0 for the whole write.
